// File: rtl/regfile_pkg.sv
// Shared register-file widths and the writeback request record used by the
// writeback scheduler and its arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: starting at ptr and wrapping modulo N, the first active
// request wins. Produces a one-hot grant and the winner's index.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W:0]   cand;

    // cand walks ptr, ptr+1, ... folded back into 0..N-1 so non-power-of-two N works
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                idx                   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between NUM_REQ writeback sources with
// round-robin arbitration and keeps the per-register busy scoreboard for decode.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter bit DROP_X0 = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*5-1:0]    req_addr,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    input  logic                    set_valid,
    output logic                    set_ready,
    input  logic [4:0]              set_addr,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic [31:0]             busy_vec
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wb_req_t [NUM_REQ-1:0]  reqs;
    wb_req_t                win;
    logic [NUM_REQ-1:0]     gnt;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       ptr_next;
    logic [IDX_W:0]         ptr_inc;
    logic [NUM_REGS-1:0]    busy;
    logic [NUM_REGS-1:0]    busy_next;
    logic                   transfer;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign reqs[i].addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
        assign reqs[i].data = req_data[REG_DATA_W*i +: REG_DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx)
    );

    // Grants are suppressed during reset so nothing transfers on a reset edge
    assign req_ready = reset ? '0 : gnt;
    assign transfer  = |req_ready;
    assign set_ready = ~reset & set_valid & ~busy[set_addr];
    assign rs1_busy  = busy[rs1];
    assign rs2_busy  = busy[rs2];
    assign busy_vec  = busy;

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win = reqs[i];
            end
        end
    end

    always_comb begin
        ptr_inc = {1'b0, win_idx} + (IDX_W+1)'(1);
        if (ptr_inc >= (IDX_W+1)'(NUM_REQ)) begin
            ptr_inc = '0;
        end
        ptr_next = ptr_inc[IDX_W-1:0];
    end

    // Clear is applied before set so a same-edge set of the same register wins
    always_comb begin
        busy_next = busy;
        if (transfer) begin
            busy_next[win.addr] = 1'b0;
        end
        if (set_ready) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= '0;
            rr_ptr   <= '0;
        end else begin
            busy <= busy_next;
            if (transfer) begin
                rr_ptr <= ptr_next;
                if (DROP_X0 && (win.addr == '0)) begin
                    rf_we <= 1'b0;
                end else begin
                    rf_we    <= 1'b1;
                    rf_waddr <= win.addr;
                    rf_wdata <= win.data;
                end
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed hazard/arbitration scenarios plus a
// randomized phase, all compared against a behavioural scoreboard model.
module tb_regfile_wb_scheduler;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*5-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [31:0]     rf_wdata;
    logic            set_valid;
    logic            set_ready;
    logic [4:0]      set_addr;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [31:0]     busy_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          busy_m [32];
    int          ptr_m;
    bit          we_m;
    logic [4:0]  waddr_m;
    logic [31:0] wdata_m;
    int          last_win;

    bit          pv [N];
    logic [4:0]  pa [N];
    logic [31:0] pd [N];

    regfile_wb_scheduler #(.NUM_REQ(N), .DROP_X0(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_addr  (set_addr),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int i, input bit v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]        = v;
        req_addr[5*i +: 5]  = a;
        req_data[32*i +: 32] = d;
    endtask

    function automatic logic [31:0] busy_model_vec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = busy_m[r];
        return v;
    endfunction

    // One clock: compare everything at the falling edge, then advance the model
    task automatic cycle();
        int win;
        bit exp_set;
        logic [4:0] a;
        @(negedge clk);
        win = -1;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                int i = (ptr_m + k) % N;
                if (win < 0 && req_valid[i]) win = i;
            end
        end
        exp_set = !reset && set_valid && !busy_m[set_addr];
        checkOutput("req_ready", 64'(req_ready), (win >= 0) ? (64'd1 << win) : 64'd0);
        checkOutput("set_ready", 64'(set_ready), 64'(exp_set));
        checkOutput("rs1_busy", 64'(rs1_busy), 64'(busy_m[rs1]));
        checkOutput("rs2_busy", 64'(rs2_busy), 64'(busy_m[rs2]));
        checkOutput("rf_we", 64'(rf_we), 64'(we_m));
        checkOutput("busy_vec", 64'(busy_vec), 64'(busy_model_vec()));
        checkOutput("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        checkOutput("busy0_zero", 64'(busy_vec[0]), 64'd0);
        if (we_m) begin
            checkOutput("rf_waddr", 64'(rf_waddr), 64'(waddr_m));
            checkOutput("rf_wdata", 64'(rf_wdata), 64'(wdata_m));
        end
        last_win = win;
        if (reset) begin
            foreach (busy_m[r]) busy_m[r] = 1'b0;
            ptr_m = 0;
            we_m  = 1'b0;
            last_win = -1;
        end else begin
            we_m = 1'b0;
            if (win >= 0) begin
                a = req_addr[5*win +: 5];
                if (a != 5'd0) begin
                    we_m    = 1'b1;
                    waddr_m = a;
                    wdata_m = req_data[32*win +: 32];
                end
                busy_m[a] = 1'b0;
                ptr_m = (win + 1) % N;
            end
            if (exp_set && set_addr != 5'd0) busy_m[set_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '1;
        req_addr  = {5'd6, 5'd5};
        req_data  = {32'h12345678, 32'hDEADBEEF};
        set_valid = 1'b1;
        set_addr  = 5'd4;
        rs1       = 5'd4;
        rs2       = 5'd5;
        foreach (busy_m[r]) busy_m[r] = 1'b0;
        ptr_m = 0; we_m = 1'b0; waddr_m = '0; wdata_m = '0; last_win = -1;
        foreach (pv[i]) begin pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; end

        // Reset held with every input active
        @(posedge clk); #1;
        repeat (3) begin
            checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
            checkOutput("rst_set_ready", 64'(set_ready), 64'd0);
            cycle();
        end
        checkOutput("rst_busy", 64'(busy_vec), 64'd0);
        checkOutput("rst_we", 64'(rf_we), 64'd0);

        // Alternating grants from rr_ptr=0
        reset = 1'b0; set_valid = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            checkOutput("t2_grant", 64'(req_ready), (g % 2) ? 64'd2 : 64'd1);
            cycle();
            checkOutput("t2_we", 64'(rf_we), 64'd1);
            checkOutput("t2_waddr", 64'(rf_waddr), (g % 2) ? 64'd6 : 64'd5);
        end
        req_valid = '0;
        cycle();

        // Set then clear reg 7
        set_valid = 1'b1; set_addr = 5'd7; rs1 = 5'd7;
        #1;
        checkOutput("t3_set_ready", 64'(set_ready), 64'd1);
        cycle();
        set_valid = 1'b0;
        #1;
        checkOutput("t3_busy7", 64'(busy_vec[7]), 64'd1);
        checkOutput("t3_rs1_busy", 64'(rs1_busy), 64'd1);
        applyStimulus(0, 1'b1, 5'd7, 32'hA5A5_0007);
        cycle();
        applyStimulus(0, 1'b0, 5'd7, 32'hA5A5_0007);
        #1;
        checkOutput("t3_we", 64'(rf_we), 64'd1);
        checkOutput("t3_waddr", 64'(rf_waddr), 64'd7);
        checkOutput("t3_busy7_clr", 64'(busy_vec[7]), 64'd0);

        // WAW stall on reg 9 released by a writeback
        set_valid = 1'b1; set_addr = 5'd9;
        cycle();
        #1;
        checkOutput("t4_stall", 64'(set_ready), 64'd0);
        applyStimulus(1, 1'b1, 5'd9, 32'h0000_0909);
        cycle();
        applyStimulus(1, 1'b0, 5'd9, 32'h0000_0909);
        #1;
        checkOutput("t4_busy9", 64'(busy_vec[9]), 64'd0);
        checkOutput("t4_set_ready", 64'(set_ready), 64'd1);
        cycle();
        set_valid = 1'b0;

        // Same-edge set and clear of reg 3
        set_valid = 1'b1; set_addr = 5'd3;
        applyStimulus(0, 1'b1, 5'd3, 32'h0000_0333);
        cycle();
        set_valid = 1'b0;
        applyStimulus(0, 1'b0, 5'd3, 32'h0000_0333);
        #1;
        checkOutput("t5_busy3", 64'(busy_vec[3]), 64'd1);

        // Write to x0 is consumed but dropped, pointer still advances
        applyStimulus(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        checkOutput("t6_ready", 64'(req_ready), 64'd1);
        cycle();
        #1;
        checkOutput("t6_we", 64'(rf_we), 64'd0);
        applyStimulus(0, 1'b1, 5'd1, 32'h1111_1111);
        applyStimulus(1, 1'b1, 5'd2, 32'h2222_2222);
        #1;
        checkOutput("t6_ptr1", 64'(req_ready), 64'd2);
        cycle();
        req_valid = '0;
        cycle();

        // Randomized traffic with occasional mid-operation resets
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1'b1;
                    pa[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                    pd[i] = $urandom;
                end
                applyStimulus(i, pv[i], pa[i], pd[i]);
            end
            set_valid = 1'($urandom_range(0, 1));
            set_addr  = 5'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 99) == 0);
            cycle();
            if (last_win >= 0) pv[last_win] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
